// File: rtl/life_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : life_scheduler_if
// Description : Control, cursor and edit-memory bundle of life_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface life_scheduler_if #(
    parameter int LOG_MAX_SPEED  = 4,
    parameter int LOG_BOARD_SIZE = 6,
    parameter int LOG_WORD_SIZE  = 4,
    parameter int LOG_MAX_ADDR   = 9
);
    localparam int c_WORD_SIZE = 2**LOG_WORD_SIZE;

    logic                      frame_tick_in;
    logic [LOG_MAX_SPEED-1:0]  speed_in;
    logic                      step_in;
    logic [LOG_BOARD_SIZE-1:0] cursor_x_in;
    logic [LOG_BOARD_SIZE-1:0] cursor_y_in;
    logic                      cursor_click_in;
    logic                      engine_done_in;
    logic                      engine_start_out;
    logic                      rd_bank_out;
    logic [LOG_MAX_ADDR-1:0]   edit_addr_out;
    logic                      edit_rd_out;
    logic [c_WORD_SIZE-1:0]    edit_data_in;
    logic [c_WORD_SIZE-1:0]    edit_data_out;
    logic                      edit_wr_out;
    logic                      busy_out;
    logic [15:0]               gen_count_out;

    // Scheduler side
    modport master (
        input  frame_tick_in, speed_in, step_in, cursor_x_in, cursor_y_in,
               cursor_click_in, engine_done_in, edit_data_in,
        output engine_start_out, rd_bank_out, edit_addr_out, edit_rd_out,
               edit_data_out, edit_wr_out, busy_out, gen_count_out
    );

    // UI / engine / memory side
    modport slave (
        output frame_tick_in, speed_in, step_in, cursor_x_in, cursor_y_in,
               cursor_click_in, engine_done_in, edit_data_in,
        input  engine_start_out, rd_bank_out, edit_addr_out, edit_rd_out,
               edit_data_out, edit_wr_out, busy_out, gen_count_out
    );
endinterface
`default_nettype wire

// File: rtl/life_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : life_scheduler
// Description : Paces Life generations, swaps board banks and performs
//               read-modify-write cell toggles between generations.
//               Optional macro LIFE_SCHED_STEP_EN adds single-step support.
// Revision    : 1.0 - initial release
// ============================================================================
module life_scheduler #(
    parameter int LOG_MAX_SPEED  = 4,
    parameter int LOG_BOARD_SIZE = 6,
    parameter int LOG_WORD_SIZE  = 4,
    parameter int LOG_MAX_ADDR   = 9,
    parameter int RD_LATENCY     = 2
) (
    input wire clk_in,
    input wire rst_in,
    life_scheduler_if.master bus
);
    localparam int c_WORD_SIZE  = 2**LOG_WORD_SIZE;
    localparam int c_ROW_SHIFT  = LOG_BOARD_SIZE - LOG_WORD_SIZE;
    localparam int c_BANK_SHIFT = 2*LOG_BOARD_SIZE - LOG_WORD_SIZE;
    localparam int c_WAIT_W     = $clog2(RD_LATENCY + 1);
    localparam logic [c_WAIT_W-1:0]      c_WAIT_LAST  = c_WAIT_W'(RD_LATENCY - 1);
    localparam logic [LOG_MAX_SPEED:0]   c_SPEED_SPAN = (LOG_MAX_SPEED+1)'(2**LOG_MAX_SPEED);
    localparam logic [c_WORD_SIZE-1:0]   c_MSB        = {1'b1, {(c_WORD_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_EDIT_RD   = 3'd2,
        S_EDIT_WAIT = 3'd3,
        S_EDIT_WR   = 3'd4
    } state_t;

    state_t                    r_state;
    logic [LOG_MAX_SPEED:0]    r_frame_cnt;
    logic                      r_pend_valid;
    logic [LOG_BOARD_SIZE-1:0] r_pend_x;
    logic [LOG_BOARD_SIZE-1:0] r_pend_y;
    logic [c_WAIT_W-1:0]       r_wait_cnt;
    logic                      r_engine_start;
    logic                      r_rd_bank;
    logic [LOG_MAX_ADDR-1:0]   r_edit_addr;
    logic                      r_edit_rd;
    logic [c_WORD_SIZE-1:0]    r_edit_data;
    logic                      r_edit_wr;
    logic                      r_busy;
    logic [15:0]               r_gen_count;

    logic [LOG_MAX_SPEED:0]    w_period;
    logic                      w_period_due;
    logic                      w_start_req;
    logic                      w_fire;
    logic                      w_pend_clear;
    logic [LOG_MAX_ADDR-1:0]   w_edit_addr;
    logic [c_WORD_SIZE-1:0]    w_mask;

    assign w_period     = c_SPEED_SPAN - {1'b0, bus.speed_in};
    assign w_period_due = (bus.speed_in != '0) && (r_frame_cnt >= w_period);
    // Edits take priority, so a start only fires from IDLE with nothing pending
    assign w_fire       = (r_state == S_IDLE) && !r_pend_valid && w_start_req;
    assign w_pend_clear = (r_state == S_EDIT_WR);

    assign w_edit_addr = (LOG_MAX_ADDR'(r_rd_bank) << c_BANK_SHIFT)
                       + (LOG_MAX_ADDR'(r_pend_y) << c_ROW_SHIFT)
                       + LOG_MAX_ADDR'(r_pend_x[LOG_BOARD_SIZE-1:LOG_WORD_SIZE]);
    // Leftmost column lives in the word MSB
    assign w_mask = c_MSB >> r_pend_x[LOG_WORD_SIZE-1:0];

`ifdef LIFE_SCHED_STEP_EN
    logic r_step_req;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_step_req <= 1'b0;
        end else if (bus.step_in && (bus.speed_in == '0)) begin
            r_step_req <= 1'b1;
        end else if (w_fire) begin
            r_step_req <= 1'b0;
        end
    end

    assign w_start_req = w_period_due || r_step_req;
`else
    logic w_unused_step;
    assign w_unused_step = bus.step_in;
    assign w_start_req   = w_period_due;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_frame_cnt <= '0;
        end else if (w_fire) begin
            r_frame_cnt <= '0;
        end else if (bus.frame_tick_in && (r_frame_cnt != '1)) begin
            r_frame_cnt <= r_frame_cnt + (LOG_MAX_SPEED+1)'(1);
        end
    end

    // A click landing on the clearing cycle replaces the finished edit
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pend_valid <= 1'b0;
            r_pend_x     <= '0;
            r_pend_y     <= '0;
        end else begin
            if (w_pend_clear) begin
                r_pend_valid <= 1'b0;
            end
            if (bus.cursor_click_in && (!r_pend_valid || w_pend_clear)) begin
                r_pend_valid <= 1'b1;
                r_pend_x     <= bus.cursor_x_in;
                r_pend_y     <= bus.cursor_y_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= S_IDLE;
            r_wait_cnt     <= '0;
            r_engine_start <= 1'b0;
            r_rd_bank      <= 1'b0;
            r_edit_addr    <= '0;
            r_edit_rd      <= 1'b0;
            r_edit_data    <= '0;
            r_edit_wr      <= 1'b0;
            r_busy         <= 1'b0;
            r_gen_count    <= '0;
        end else begin
            r_engine_start <= 1'b0;
            r_edit_rd      <= 1'b0;
            r_edit_wr      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pend_valid) begin
                        r_state     <= S_EDIT_RD;
                        r_edit_rd   <= 1'b1;
                        r_edit_addr <= w_edit_addr;
                        r_busy      <= 1'b1;
                    end else if (w_fire) begin
                        r_state        <= S_RUN;
                        r_engine_start <= 1'b1;
                        r_busy         <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.engine_done_in) begin
                        r_state     <= S_IDLE;
                        r_rd_bank   <= ~r_rd_bank;
                        r_gen_count <= r_gen_count + 16'd1;
                        r_busy      <= 1'b0;
                    end
                end
                S_EDIT_RD: begin
                    r_state    <= S_EDIT_WAIT;
                    r_wait_cnt <= '0;
                end
                S_EDIT_WAIT: begin
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state     <= S_EDIT_WR;
                        r_edit_data <= bus.edit_data_in ^ w_mask;
                        r_edit_wr   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                S_EDIT_WR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.engine_start_out = r_engine_start;
    assign bus.rd_bank_out      = r_rd_bank;
    assign bus.edit_addr_out    = r_edit_addr;
    assign bus.edit_rd_out      = r_edit_rd;
    assign bus.edit_data_out    = r_edit_data;
    assign bus.edit_wr_out      = r_edit_wr;
    assign bus.busy_out         = r_busy;
    assign bus.gen_count_out    = r_gen_count;
endmodule
`default_nettype wire

// File: tb/tb_life_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_scheduler
// Description : Scoreboard bench for life_scheduler with an edit-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_scheduler;
    localparam int LMS = 4;
    localparam int LBS = 6;
    localparam int LWS = 4;
    localparam int LMA = 9;
    localparam int RDL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    life_scheduler_if #(.LOG_MAX_SPEED(LMS), .LOG_BOARD_SIZE(LBS),
                        .LOG_WORD_SIZE(LWS), .LOG_MAX_ADDR(LMA)) bus ();

    life_scheduler #(.LOG_MAX_SPEED(LMS), .LOG_BOARD_SIZE(LBS), .LOG_WORD_SIZE(LWS),
                     .LOG_MAX_ADDR(LMA), .RD_LATENCY(RDL)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [LMA-1:0] addr;
        logic [15:0]    data;
    } edit_t;

    edit_t       exp_q[$];
    edit_t       mon_e;
    logic [15:0] mem [0:(2**LMA)-1];
    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int n_starts = 0;
    int rd_cyc = -100;
    int rd_cnt = 0;
    logic [LMA-1:0] rd_addr;
    bit drive_active = 0;
    bit prev_wr = 0;
    int exp_bank = 0;
    int exp_gen = 0;

    // Memory model, strobe monitor and edit scoreboard
    always @(negedge clk) begin
        cyc++;
        if (drive_active) begin
            bus.edit_data_in = 16'hA5A5;
            drive_active = 0;
        end
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                bus.edit_data_in = mem[rd_addr];
                drive_active = 1;
            end
        end
        if (rst) begin
            rd_cnt = 0;
            prev_wr = 0;
        end else begin
            if (prev_wr) begin
                tests_run++;
                if (bus.busy_out !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL busy_after_wr: busy=%b required 0", bus.busy_out);
                end
            end
            prev_wr = 0;
            if (bus.engine_start_out === 1'b1) n_starts++;
            if (bus.edit_rd_out === 1'b1) begin
                rd_cnt = RDL;
                rd_addr = bus.edit_addr_out;
                rd_cyc = cyc;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL edit_rd: unexpected read at addr=%0d", bus.edit_addr_out);
                end else if (bus.edit_addr_out !== exp_q[0].addr) begin
                    tests_failed++;
                    $display("FAIL edit_rd_addr: got %0d required %0d", bus.edit_addr_out, exp_q[0].addr);
                end
            end
            if (bus.edit_wr_out === 1'b1) begin
                prev_wr = 1;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL edit_wr: unexpected write addr=%0d data=%h",
                             bus.edit_addr_out, bus.edit_data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.edit_addr_out !== mon_e.addr || bus.edit_data_out !== mon_e.data ||
                        (cyc - rd_cyc) != RDL + 1) begin
                        tests_failed++;
                        $display("FAIL edit_wr: addr=%0d/%0d data=%h/%h latency=%0d/%0d (got/required)",
                                 bus.edit_addr_out, mon_e.addr, bus.edit_data_out, mon_e.data,
                                 cyc - rd_cyc, RDL + 1);
                    end
                end
                mem[bus.edit_addr_out] = bus.edit_data_out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_edit(input int x, input int y, input int bank);
        edit_t e;
        int a;
        a = bank * (2**(2*LBS-LWS)) + y * (2**(LBS-LWS)) + x / (2**LWS);
        e.addr = a[LMA-1:0];
        e.data = mem[a] ^ (16'h8000 >> (x % (2**LWS)));
        exp_q.push_back(e);
    endfunction

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        bus.frame_tick_in = 1'b1;
        step_cycles(1);
        bus.frame_tick_in = 1'b0;
    endtask

    // Done while the engine is running: the bench model swaps and counts
    task automatic pulse_done();
        bus.engine_done_in = 1'b1;
        step_cycles(1);
        bus.engine_done_in = 1'b0;
        exp_bank = 1 - exp_bank;
        exp_gen++;
    endtask

    task automatic click(input int x, input int y);
        bus.cursor_x_in = x[LBS-1:0];
        bus.cursor_y_in = y[LBS-1:0];
        bus.cursor_click_in = 1'b1;
        step_cycles(1);
        bus.cursor_click_in = 1'b0;
    endtask

    task automatic wait_start(input int max, output int lat);
        lat = -1;
        for (int k = 1; k <= max; k++) begin
            step_cycles(1);
            if (bus.engine_start_out === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_edits(input int max, output bit ok);
        ok = 0;
        for (int k = 0; k < max; k++) begin
            step_cycles(1);
            if (exp_q.size() == 0 && bus.busy_out === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step_cycles(3);
        tests_run++;
        if ({bus.engine_start_out, bus.rd_bank_out, bus.edit_rd_out, bus.edit_wr_out, bus.busy_out} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: start,bank,rd,wr,busy=%b required 00000",
                     {bus.engine_start_out, bus.rd_bank_out, bus.edit_rd_out, bus.edit_wr_out, bus.busy_out});
        end
        tests_run++;
        if (bus.edit_addr_out !== '0 || bus.edit_data_out !== '0 || bus.gen_count_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: addr=%0d data=%h gen=%0d required 0", bus.edit_addr_out,
                     bus.edit_data_out, bus.gen_count_out);
        end
        rst = 1'b0;
        step_cycles(3);
        tests_run++;
        if (bus.busy_out !== 1'b0 || n_starts != 0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy=%b starts=%0d required 0/0", bus.busy_out, n_starts);
        end
    endtask

    task automatic test_speed();
        int lat;
        int base;
        base = n_starts;
        bus.speed_in = 4'd14;
        pulse_tick();
        step_cycles(4);
        tests_run++;
        if (n_starts != base) begin
            tests_failed++;
            $display("FAIL speed_one_tick: starts=%0d required %0d", n_starts, base);
        end
        pulse_tick();
        wait_start(5, lat);
        tests_run++;
        if (lat != 1 || bus.busy_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL speed_start: latency=%0d busy=%b required 1/1", lat, bus.busy_out);
        end
        step_cycles(9);
        pulse_done();
        tests_run++;
        if (bus.rd_bank_out !== exp_bank[0] || bus.gen_count_out !== exp_gen[15:0] || bus.busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL speed_swap: bank=%b gen=%0d busy=%b required %0d/%0d/0",
                     bus.rd_bank_out, bus.gen_count_out, bus.busy_out, exp_bank, exp_gen);
        end
        // Done outside RUN must not swap or count
        bus.engine_done_in = 1'b1;
        step_cycles(1);
        bus.engine_done_in = 1'b0;
        step_cycles(1);
        tests_run++;
        if (bus.rd_bank_out !== exp_bank[0] || bus.gen_count_out !== exp_gen[15:0]) begin
            tests_failed++;
            $display("FAIL stray_done: bank=%b gen=%0d required %0d/%0d",
                     bus.rd_bank_out, bus.gen_count_out, exp_bank, exp_gen);
        end
    endtask

    task automatic test_pause();
        int lat;
        int base;
        bus.speed_in = 4'd0;
        base = n_starts;
        repeat (40) begin
            pulse_tick();
            step_cycles(1);
        end
        tests_run++;
        if (n_starts != base) begin
            tests_failed++;
            $display("FAIL pause: starts=%0d required %0d", n_starts, base);
        end
        bus.speed_in = 4'd15;
        wait_start(2, lat);
        tests_run++;
        if (lat < 1 || lat > 2) begin
            tests_failed++;
            $display("FAIL unpause_start: latency=%0d required 1..2", lat);
        end
        bus.speed_in = 4'd0;
        step_cycles(3);
        pulse_done();
        tests_run++;
        if (bus.rd_bank_out !== exp_bank[0] || bus.gen_count_out !== exp_gen[15:0]) begin
            tests_failed++;
            $display("FAIL pause_swap: bank=%b gen=%0d required %0d/%0d",
                     bus.rd_bank_out, bus.gen_count_out, exp_bank, exp_gen);
        end
    endtask

    task automatic test_edit_idle();
        bit ok;
        push_edit(17, 3, exp_bank);
        click(17, 3);
        wait_edits(20, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL edit_idle: pending=%0d busy=%b required 0/0", exp_q.size(), bus.busy_out);
        end
    endtask

    task automatic test_edit_run();
        int lat;
        bit ok;
        bus.speed_in = 4'd15;
        pulse_tick();
        wait_start(4, lat);
        bus.speed_in = 4'd0;
        tests_run++;
        if (lat == -1) begin
            tests_failed++;
            $display("FAIL run_start: latency=%0d required 1..4", lat);
        end
        step_cycles(2);
        push_edit(0, 0, 1 - exp_bank);
        click(0, 0);
        step_cycles(4);
        tests_run++;
        if (exp_q.size() != 1 || bus.busy_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL edit_held_in_run: pending=%0d busy=%b required 1/1", exp_q.size(), bus.busy_out);
        end
        pulse_done();
        wait_edits(20, ok);
        tests_run++;
        if (!ok || bus.rd_bank_out !== exp_bank[0] || bus.gen_count_out !== exp_gen[15:0]) begin
            tests_failed++;
            $display("FAIL edit_after_swap: ok=%0d bank=%b gen=%0d required 1/%0d/%0d",
                     ok, bus.rd_bank_out, bus.gen_count_out, exp_bank, exp_gen);
        end
    endtask

    task automatic test_drop();
        int lat;
        bit ok;
        bus.speed_in = 4'd15;
        pulse_tick();
        wait_start(4, lat);
        bus.speed_in = 4'd0;
        push_edit(5, 10, 1 - exp_bank);
        click(5, 10);
        step_cycles(2);
        click(40, 60);
        step_cycles(2);
        pulse_done();
        wait_edits(20, ok);
        step_cycles(15);
        tests_run++;
        if (!ok || lat == -1 || exp_q.size() != 0 || bus.busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_second_click: ok=%0d lat=%0d pending=%0d busy=%b required 1/>0/0/0",
                     ok, lat, exp_q.size(), bus.busy_out);
        end
    endtask

    task automatic test_priority();
        int lat;
        bus.speed_in = 4'd15;
        push_edit(63, 63, exp_bank);
        bus.cursor_x_in = 6'd63;
        bus.cursor_y_in = 6'd63;
        bus.cursor_click_in = 1'b1;
        bus.frame_tick_in = 1'b1;
        step_cycles(1);
        bus.cursor_click_in = 1'b0;
        bus.frame_tick_in = 1'b0;
        wait_start(20, lat);
        tests_run++;
        if (lat == -1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL edit_before_start: lat=%0d pending=%0d required >0/0", lat, exp_q.size());
        end
        bus.speed_in = 4'd0;
        step_cycles(2);
        pulse_done();
        tests_run++;
        if (bus.rd_bank_out !== exp_bank[0] || bus.gen_count_out !== exp_gen[15:0]) begin
            tests_failed++;
            $display("FAIL priority_swap: bank=%b gen=%0d required %0d/%0d",
                     bus.rd_bank_out, bus.gen_count_out, exp_bank, exp_gen);
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        bit ok;
        found = 0;
        push_edit(16, 0, exp_bank);
        click(16, 0);
        for (int k = 0; k < 10; k++) begin
            if (bus.edit_wr_out === 1'b1) begin
                found = 1;
                break;
            end
            step_cycles(1);
        end
        // Click lands in the same cycle the first edit is cleared
        push_edit(31, 1, exp_bank);
        click(31, 1);
        wait_edits(20, ok);
        tests_run++;
        if (!found || !ok) begin
            tests_failed++;
            $display("FAIL back_to_back: wr_seen=%0d ok=%0d pending=%0d required 1/1/0", found, ok, exp_q.size());
        end
    endtask

    task automatic test_step();
        int base;
        base = n_starts;
        bus.speed_in = 4'd0;
        bus.step_in = 1'b1;
        step_cycles(1);
        bus.step_in = 1'b0;
        step_cycles(6);
`ifdef LIFE_SCHED_STEP_EN
        tests_run++;
        if (n_starts != base + 1) begin
            tests_failed++;
            $display("FAIL step_start: starts=%0d required %0d", n_starts, base + 1);
        end
        pulse_done();
        step_cycles(4);
        tests_run++;
        if (n_starts != base + 1 || bus.gen_count_out !== exp_gen[15:0]) begin
            tests_failed++;
            $display("FAIL step_once: starts=%0d gen=%0d required %0d/%0d",
                     n_starts, bus.gen_count_out, base + 1, exp_gen);
        end
`else
        tests_run++;
        if (n_starts != base || bus.busy_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL step_ignored: starts=%0d busy=%b required %0d/0", n_starts, bus.busy_out, base);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit found;
        int base;
        found = 0;
        push_edit(1, 2, exp_bank);
        click(1, 2);
        for (int k = 0; k < 10; k++) begin
            if (bus.edit_rd_out === 1'b1) begin
                found = 1;
                break;
            end
            step_cycles(1);
        end
        step_cycles(1);
        rst = 1'b1;
        step_cycles(1);
        tests_run++;
        if (!found || {bus.engine_start_out, bus.rd_bank_out, bus.edit_rd_out, bus.edit_wr_out, bus.busy_out} !== 5'b0) begin
            tests_failed++;
            $display("FAIL midreset_strobes: rd_seen=%0d start,bank,rd,wr,busy=%b required 1/00000", found,
                     {bus.engine_start_out, bus.rd_bank_out, bus.edit_rd_out, bus.edit_wr_out, bus.busy_out});
        end
        tests_run++;
        if (bus.edit_addr_out !== '0 || bus.edit_data_out !== '0 || bus.gen_count_out !== '0) begin
            tests_failed++;
            $display("FAIL midreset_values: addr=%0d data=%h gen=%0d required 0",
                     bus.edit_addr_out, bus.edit_data_out, bus.gen_count_out);
        end
        exp_q.delete();
        exp_bank = 0;
        exp_gen = 0;
        base = n_starts;
        rst = 1'b0;
        step_cycles(12);
        tests_run++;
        if (bus.busy_out !== 1'b0 || n_starts != base) begin
            tests_failed++;
            $display("FAIL midreset_quiet: busy=%b starts=%0d required 0/%0d", bus.busy_out, n_starts, base);
        end
    endtask

    initial begin
        for (int i = 0; i < 2**LMA; i++) mem[i] = 16'h0000;
        mem[256] = 16'h1234;
        mem[40]  = 16'hFFFF;
        bus.frame_tick_in   = 1'b0;
        bus.speed_in        = '0;
        bus.step_in         = 1'b0;
        bus.cursor_x_in     = '0;
        bus.cursor_y_in     = '0;
        bus.cursor_click_in = 1'b0;
        bus.engine_done_in  = 1'b0;
        bus.edit_data_in    = 16'hA5A5;

        test_reset();
        test_speed();
        test_pause();
        test_edit_idle();
        test_edit_run();
        test_drop();
        test_priority();
        test_back_to_back();
        test_step();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/life_scheduler.md
# life_scheduler

Generation sequencer for the Life engine. Paces generations from the frame tick and `speed_in`, pulses the fetcher/updater start, and on completion swaps the double-buffered board banks. Between generations it arbitrates the shared board memory for cursor edits, performing a read-modify-write toggle of the clicked cell. Sits between the UI/cursor logic and the `life_logic` datapath.

## Interface

Parameters:
- `LOG_MAX_SPEED`, default 4: width of `speed_in`.
- `LOG_BOARD_SIZE`, default 6: board side is `BOARD_SIZE = 2**LOG_BOARD_SIZE`.
- `LOG_WORD_SIZE`, default 4: memory word is `WORD_SIZE = 2**LOG_WORD_SIZE` bits.
- `LOG_MAX_ADDR`, default 9: address width. Must be at least large enough for two banks.
- `RD_LATENCY`, default 2: memory read latency in cycles.

Ports:
- `clk_in`, in, 1: clock.
- `rst_in`, in, 1: reset, synchronous, active-high.
- `frame_tick_in`, in, 1: one-cycle pulse per video frame.
- `speed_in`, in, `LOG_MAX_SPEED`: 0 means paused. Otherwise the period is `2**LOG_MAX_SPEED - speed_in` frames.
- `step_in`, in, 1: single-step pulse. Only used with `LIFE_SCHED_STEP_EN`.
- `cursor_x_in`, `cursor_y_in`, in, `LOG_BOARD_SIZE` each: coordinates of the clicked cell.
- `cursor_click_in`, in, 1: one-cycle edit request.
- `engine_done_in`, in, 1: one-cycle pulse from the engine when a generation is complete.
- `engine_start_out`, out, 1: one-cycle generation start pulse.
- `rd_bank_out`, out, 1: bank currently displayed and read by the engine. The engine writes bank `~rd_bank_out`.
- `edit_addr_out`, out, `LOG_MAX_ADDR`: edit read/write address.
- `edit_rd_out`, out, 1: edit read strobe.
- `edit_data_in`, in, `WORD_SIZE`: read data, valid `RD_LATENCY` cycles after the strobe.
- `edit_data_out`, out, `WORD_SIZE`: edit write data.
- `edit_wr_out`, out, 1: edit write strobe.
- `busy_out`, out, 1: high in any state other than IDLE.
- `gen_count_out`, out, 16: number of completed generations. Wraps.

## Operation

- The states are IDLE, RUN, EDIT_RD, EDIT_WAIT and EDIT_WR.
- Bank `b` starts at word `b * BOARD_SIZE*BOARD_SIZE/WORD_SIZE`.
- **Frame counter** (`LOG_MAX_SPEED+1` bits):
  - Increments on `frame_tick_in` and saturates at its maximum value.
  - Keeps counting in every state.
  - Compares against the current `speed_in` every cycle, so a speed change takes effect immediately.
- **Pending edit**: a one-deep register capturing x, y and a valid flag when `cursor_click_in` is high. A click arriving while an edit is already pending is dropped.
- **IDLE**, priority order:
  1. If an edit is pending, go to EDIT_RD.
  2. Else, if `speed_in != 0` and the frame count is at least the period: pulse `engine_start_out`, clear the frame counter, go to RUN.
  3. Else, remain in IDLE.
- **RUN**:
  - Waits for `engine_done_in`.
  - On done: toggle `rd_bank_out`, increment `gen_count_out`, return to IDLE.
  - Clicks are captured during RUN but not serviced.
- **EDIT_RD**:
  - `edit_addr_out = bank_base(rd_bank_out) + y*(BOARD_SIZE/WORD_SIZE) + x[LOG_BOARD_SIZE-1:LOG_WORD_SIZE]`.
  - Pulse `edit_rd_out` for one cycle, then go to EDIT_WAIT.
- **EDIT_WAIT**: count `RD_LATENCY` cycles, latch `edit_data_in`, go to EDIT_WR.
- **EDIT_WR**:
  - `edit_data_out` is the latched word with bit `WORD_SIZE-1-x[LOG_WORD_SIZE-1:0]` inverted. The MSB is the leftmost column.
  - Pulse `edit_wr_out` for one cycle at the same address.
  - Clear the pending edit and return to IDLE.
- **Simultaneous events**:
  - Click and `engine_done_in` in the same cycle: the swap happens, and the edit is applied to the new `rd_bank_out`.
  - Click in the same cycle the pending edit is cleared: the new click is captured.
  - `engine_done_in` outside RUN is ignored.

## Timing

- Reset values:
  - State IDLE.
  - All strobes 0.
  - `rd_bank_out` = 0.
  - `edit_addr_out` and `edit_data_out` = 0.
  - `gen_count_out` = 0.
  - `busy_out` = 0.
  - Frame counter 0; pending edit cleared.
- Reset mid-operation aborts immediately and no further strobes are issued. The engine is reset by the same `rst_in`.
- All outputs are registered.
- `engine_start_out` rises the cycle after IDLE sees its condition, and `busy_out` rises in the same cycle.
- Bank swap: `rd_bank_out` toggles the cycle after `engine_done_in`.
- Edit latency: `edit_rd_out` at cycle t, data latched at t+`RD_LATENCY`, `edit_wr_out` at t+`RD_LATENCY`+1. `busy_out` returns low the cycle after the write.
- Minimum gap between two `engine_start_out` pulses is (engine runtime + 2) cycles.

## Configuration

- `LIFE_SCHED_STEP_EN`:
  - Defined: a `step_in` pulse while `speed_in == 0` sets a one-deep step request. IDLE services it with the same priority as a timed start, below edits. The request is cleared when the start pulse is issued.
  - Undefined: `step_in` is ignored and no step register is built.

## Test plan

- Speed: reset, `speed_in=14`, defaults. Expect `engine_start_out` after the 2nd `frame_tick_in`. Engine done 10 cycles later → `rd_bank_out`=1, `gen_count_out`=1.
- Pause: `speed_in=0` for 40 frame ticks → no `engine_start_out`. Set `speed_in=15` → start within 2 cycles, since the frame counter is saturated.
- Edit: in IDLE, rd bank 0, click at (x=17, y=3):
  - `edit_rd_out` with address 3*4+1=13.
  - Return data 0x0000 → `edit_wr_out` at address 13 with data 0x4000, exactly 3 cycles after the read strobe.
- Edit during RUN: click at (0,0) mid-generation, then done. Expect the swap first, then a read of 256 (bank 1 base), then a write of bit 15 toggled.
- Priority and drop:
  - Two clicks during RUN → only the first edit is performed.
  - An edit pending with the period also elapsed → the edit completes before `engine_start_out`.
- Reset: assert `rst_in` in EDIT_WAIT → no `edit_wr_out`, all outputs at reset values on the next cycle. With `LIFE_SCHED_STEP_EN` defined, `speed_in=0` and a `step_in` pulse → exactly one `engine_start_out`.
